// File: rtl/req_dispatch_arbiter_if.sv
// Packet type shared by the request FIFOs and the dispatch path, and the
// bundle of handshake signals between the arbiter and its environment.
package req_dispatch_arbiter_pkg;
    typedef struct packed {
        logic       req;
        logic [3:0] req_id;
        logic [7:0] data;
    } req_pkt_type;
endpackage

interface req_dispatch_arbiter_if #(
    parameter int NUM_PORTS       = 4,
    parameter int MAX_OUTSTANDING = 2,
    parameter int PORT_W          = $clog2(NUM_PORTS),
    parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
);
    import req_dispatch_arbiter_pkg::*;

    logic                            arb_en;
    req_pkt_type [NUM_PORTS-1:0]     port_req;
    logic        [NUM_PORTS-1:0]     port_read;
    req_pkt_type                     disp_req;
    logic        [PORT_W-1:0]        disp_port;
    logic                            disp_valid;
    logic                            disp_ready;
    logic                            resp_done;
    logic        [CNT_W-1:0]         outstanding;
    logic                            arb_busy;

    modport master (
        input  arb_en, port_req, disp_ready, resp_done,
        output port_read, disp_req, disp_port, disp_valid, outstanding, arb_busy
    );

    modport slave (
        output arb_en, port_req, disp_ready, resp_done,
        input  port_read, disp_req, disp_port, disp_valid, outstanding, arb_busy
    );
endinterface

// File: rtl/req_dispatch_arbiter.sv
// Round-robin arbiter popping one request FIFO head at a time and handing the
// packet to a single execution unit, limited by an in-flight request budget.
module req_dispatch_arbiter
    import req_dispatch_arbiter_pkg::*;
#(
    parameter int NUM_PORTS       = 4,
    parameter int MAX_OUTSTANDING = 2,
    parameter int PORT_W          = $clog2(NUM_PORTS),
    parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    req_dispatch_arbiter_if.master bus
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_t;

    state_t                 state_r;
    state_t                 next_state_s;
    logic [PORT_W-1:0]      last_grant_r;
    logic [PORT_W-1:0]      winner_s;
    logic                   found_s;
    logic                   grant_s;
    logic                   transfer_s;
    logic [NUM_PORTS-1:0]   port_read_s;
    req_pkt_type            disp_req_r;
    logic [PORT_W-1:0]      disp_port_r;
    logic                   disp_valid_r;
    logic [CNT_W-1:0]       outstanding_r;
    int                     idx_s;

    // Round-robin search starting just past the last granted port.
    always_comb begin
        found_s  = 1'b0;
        winner_s = '0;
        idx_s    = 0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            idx_s = (int'(last_grant_r) + k) % NUM_PORTS;
            if (!found_s && bus.port_req[idx_s].req) begin
                found_s  = 1'b1;
                winner_s = PORT_W'(idx_s);
            end else begin
                found_s  = found_s;
            end
        end
    end

    // Grant gating, one-hot pop pulse and the dispatch-accept condition.
    always_comb begin
        grant_s     = (state_r == ST_IDLE) && !rst && bus.arb_en && found_s &&
                      (outstanding_r < CNT_W'(MAX_OUTSTANDING));
        transfer_s  = (state_r == ST_ISSUE) && bus.disp_ready;
        port_read_s = '0;
        if (grant_s) begin
            port_read_s[winner_s] = 1'b1;
        end else begin
            port_read_s = '0;
        end
    end

    // Next-state logic of the IDLE/ISSUE controller.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (grant_s) begin
                    next_state_s = ST_ISSUE;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (bus.disp_ready) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_ISSUE;
                end
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // State, captured packet and round-robin pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            disp_req_r   <= '0;
            disp_port_r  <= '0;
            disp_valid_r <= 1'b0;
            last_grant_r <= PORT_W'(NUM_PORTS - 1);
        end else begin
            state_r <= next_state_s;
            if (grant_s) begin
                disp_req_r   <= bus.port_req[winner_s];
                disp_port_r  <= winner_s;
                last_grant_r <= winner_s;
                disp_valid_r <= 1'b1;
            end else if (transfer_s) begin
                disp_valid_r <= 1'b0;
            end
        end
    end

    // In-flight counter; a completion with nothing outstanding is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding_r <= '0;
        end else begin
            case ({transfer_s, bus.resp_done})
                2'b10:   outstanding_r <= outstanding_r + CNT_W'(1);
                2'b01: begin
                    if (outstanding_r != '0) begin
                        outstanding_r <= outstanding_r - CNT_W'(1);
                    end
                end
                default: outstanding_r <= outstanding_r;
            endcase
        end
    end

    assign bus.port_read   = port_read_s;
    assign bus.disp_req    = disp_req_r;
    assign bus.disp_port   = disp_port_r;
    assign bus.disp_valid  = disp_valid_r;
    assign bus.outstanding = outstanding_r;
    assign bus.arb_busy    = (state_r != ST_IDLE);

`ifdef INLINE_SVA
    req_dispatch_arbiter_sva #(
        .NUM_PORTS       (NUM_PORTS),
        .MAX_OUTSTANDING (MAX_OUTSTANDING),
        .CNT_W           (CNT_W)
    ) u_sva (
        .clk         (clk),
        .rst         (rst),
        .port_read   (port_read_s),
        .port_req    (bus.port_req),
        .disp_valid  (disp_valid_r),
        .disp_ready  (bus.disp_ready),
        .disp_req    (disp_req_r),
        .outstanding (outstanding_r)
    );
`endif

endmodule

`ifdef INLINE_SVA
module req_dispatch_arbiter_sva
    import req_dispatch_arbiter_pkg::*;
#(
    parameter int NUM_PORTS       = 4,
    parameter int MAX_OUTSTANDING = 2,
    parameter int CNT_W           = 2
) (
    input logic                        clk,
    input logic                        rst,
    input logic        [NUM_PORTS-1:0] port_read,
    input req_pkt_type [NUM_PORTS-1:0] port_req,
    input logic                        disp_valid,
    input logic                        disp_ready,
    input req_pkt_type                 disp_req,
    input logic        [CNT_W-1:0]     outstanding
);
    a_read_onehot: assert property (@(posedge clk) $onehot0(port_read));
    a_hold: assert property (@(posedge clk) disable iff (rst)
        disp_valid && !disp_ready |=> disp_valid && $stable(disp_req));
    a_cnt_max: assert property (@(posedge clk) outstanding <= CNT_W'(MAX_OUTSTANDING));

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_req
        a_read_req: assert property (@(posedge clk) port_read[i] |-> port_req[i].req);
    end
endmodule
`endif

// File: tb/tb_req_dispatch_arbiter.sv
// Directed scenario tasks plus a dispatch scoreboard checking every transfer.
module tb_req_dispatch_arbiter;
    import req_dispatch_arbiter_pkg::*;

    localparam int NP = 4;

    typedef struct {
        int         port;
        logic [3:0] id;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    exp_t exp_q[$];
    exp_t e;

    always #5 clk = ~clk;

    req_dispatch_arbiter_if #(.NUM_PORTS(NP), .MAX_OUTSTANDING(2)) b ();

    req_dispatch_arbiter #(.NUM_PORTS(NP), .MAX_OUTSTANDING(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (b)
    );

    function automatic logic [7:0] pkt_data(input int p, input logic [3:0] id);
        return {4'(p), id};
    endfunction

    task automatic set_req(input int p, input logic r, input logic [3:0] id);
        b.port_req[p] = '{req: r, req_id: id, data: pkt_data(p, id)};
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < NP; i++) set_req(i, 1'b0, 4'd0);
    endtask

    task automatic all_reqs(input int base);
        for (int i = 0; i < NP; i++) set_req(i, 1'b1, 4'(base + i));
    endtask

    task automatic push(input int p, input logic [3:0] id);
        exp_t x;
        x.port = p;
        x.id   = id;
        exp_q.push_back(x);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    // Scoreboard: every accepted dispatch must match the next expected packet.
    always @(negedge clk) begin
        if (!rst && b.disp_valid === 1'b1 && b.disp_ready === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected got port=%0d id=%0d want none", b.disp_port, b.disp_req.req_id);
            end else begin
                e = exp_q.pop_front();
                if (int'(b.disp_port) !== e.port || b.disp_req.req_id !== e.id ||
                    b.disp_req.data !== pkt_data(e.port, e.id) || b.disp_req.req !== 1'b1) begin
                    bad++;
                    $display("FAIL sb_dispatch got port=%0d id=%0d data=%h want port=%0d id=%0d data=%h",
                             b.disp_port, b.disp_req.req_id, b.disp_req.data, e.port, e.id, pkt_data(e.port, e.id));
                end
            end
        end
    end

    task automatic test_reset();
        all_reqs(1);
        b.arb_en = 1'b1;
        b.disp_ready = 1'b0;
        b.resp_done = 1'b0;
        rst = 1'b1;
        step();
        smp();
        total++; if (b.port_read !== 4'b0000) begin bad++; $display("FAIL rst_read got=%b want=0000", b.port_read); end
        total++; if (b.disp_valid !== 1'b0 || b.arb_busy !== 1'b0) begin bad++; $display("FAIL rst_valid got v=%b busy=%b want 0 0", b.disp_valid, b.arb_busy); end
        total++; if (b.outstanding !== 2'd0 || b.disp_port !== 2'd0 || b.disp_req !== '0) begin bad++; $display("FAIL rst_regs got out=%0d port=%0d req=%h want 0", b.outstanding, b.disp_port, b.disp_req); end
        step();
        clear_reqs();
        rst = 1'b0;
    endtask

    task automatic test_single_port();
        set_req(2, 1'b1, 4'd5);
        push(2, 4'd5);
        smp();
        total++; if (b.port_read !== 4'b0100) begin bad++; $display("FAIL t1_read got=%b want=0100", b.port_read); end
        step();
        set_req(2, 1'b0, 4'd0);
        b.disp_ready = 1'b1;
        smp();
        total++; if (b.disp_valid !== 1'b1 || b.disp_port !== 2'd2 || b.disp_req.req_id !== 4'd5) begin bad++; $display("FAIL t1_issue got v=%b port=%0d id=%0d want 1 2 5", b.disp_valid, b.disp_port, b.disp_req.req_id); end
        total++; if (b.port_read !== 4'b0000) begin bad++; $display("FAIL t1_issue_read got=%b want=0000", b.port_read); end
        step();
        smp();
        total++; if (b.outstanding !== 2'd1 || b.disp_valid !== 1'b0) begin bad++; $display("FAIL t1_out got out=%0d v=%b want 1 0", b.outstanding, b.disp_valid); end
        step();
        b.resp_done = 1'b1;
        step();
        b.resp_done = 1'b0;
        smp();
        total++; if (b.outstanding !== 2'd0) begin bad++; $display("FAIL t1_resp got=%0d want=0", b.outstanding); end
        step();
    endtask

    task automatic test_round_robin();
        do_reset();
        all_reqs(10);
        b.disp_ready = 1'b1;
        for (int k = 0; k < 5; k++) push(k % NP, 4'(10 + (k % NP)));
        for (int k = 0; k < 5; k++) begin
            b.resp_done = (k > 0);
            smp();
            total++; if (b.port_read !== 4'(1 << (k % NP)) || b.disp_valid !== 1'b0) begin bad++; $display("FAIL rr_grant%0d got read=%b v=%b want read=%b v=0", k, b.port_read, b.disp_valid, 4'(1 << (k % NP))); end
            step();
            b.resp_done = 1'b0;
            smp();
            total++; if (b.disp_valid !== 1'b1 || b.port_read !== 4'b0000) begin bad++; $display("FAIL rr_issue%0d got v=%b read=%b want 1 0000", k, b.disp_valid, b.port_read); end
            step();
        end
        clear_reqs();
        b.resp_done = 1'b1;
        step();
        b.resp_done = 1'b0;
        smp();
        total++; if (b.outstanding !== 2'd0) begin bad++; $display("FAIL rr_out got=%0d want=0", b.outstanding); end
        step();
    endtask

    task automatic test_max_outstanding();
        do_reset();
        all_reqs(1);
        b.disp_ready = 1'b1;
        push(0, 4'd1);
        push(1, 4'd2);
        push(2, 4'd3);
        smp();
        total++; if (b.port_read !== 4'b0001) begin bad++; $display("FAIL max_g0 got=%b want=0001", b.port_read); end
        step();
        step();
        smp();
        total++; if (b.port_read !== 4'b0010) begin bad++; $display("FAIL max_g1 got=%b want=0010", b.port_read); end
        step();
        step();
        for (int j = 0; j < 2; j++) begin
            smp();
            total++; if (b.port_read !== 4'b0000 || b.outstanding !== 2'd2) begin bad++; $display("FAIL max_block%0d got read=%b out=%0d want 0000 2", j, b.port_read, b.outstanding); end
            step();
        end
        b.resp_done = 1'b1;
        smp();
        total++; if (b.port_read !== 4'b0000) begin bad++; $display("FAIL max_resp_cycle got=%b want=0000", b.port_read); end
        step();
        b.resp_done = 1'b0;
        smp();
        total++; if (b.port_read !== 4'b0100 || b.outstanding !== 2'd1) begin bad++; $display("FAIL max_g2 got read=%b out=%0d want 0100 1", b.port_read, b.outstanding); end
        step();
        step();
        clear_reqs();
        smp();
        total++; if (b.outstanding !== 2'd2) begin bad++; $display("FAIL max_full got=%0d want=2", b.outstanding); end
        b.resp_done = 1'b1;
        step();
        step();
        b.resp_done = 1'b0;
        smp();
        total++; if (b.outstanding !== 2'd0) begin bad++; $display("FAIL max_drain got=%0d want=0", b.outstanding); end
        step();
    endtask

    task automatic test_backpressure();
        do_reset();
        b.disp_ready = 1'b0;
        set_req(1, 1'b1, 4'd7);
        push(1, 4'd7);
        smp();
        total++; if (b.port_read !== 4'b0010) begin bad++; $display("FAIL bp_grant got=%b want=0010", b.port_read); end
        step();
        set_req(1, 1'b0, 4'd0);
        set_req(0, 1'b1, 4'd3);
        set_req(3, 1'b1, 4'd4);
        for (int j = 0; j < 5; j++) begin
            smp();
            total++; if (b.disp_valid !== 1'b1 || b.disp_port !== 2'd1 || b.disp_req.req_id !== 4'd7 || b.arb_busy !== 1'b1) begin bad++; $display("FAIL bp_hold%0d got v=%b port=%0d id=%0d busy=%b want 1 1 7 1", j, b.disp_valid, b.disp_port, b.disp_req.req_id, b.arb_busy); end
            total++; if (b.port_read !== 4'b0000 || b.outstanding !== 2'd0) begin bad++; $display("FAIL bp_noread%0d got read=%b out=%0d want 0000 0", j, b.port_read, b.outstanding); end
            step();
        end
        clear_reqs();
        b.disp_ready = 1'b1;
        step();
        smp();
        total++; if (b.outstanding !== 2'd1 || b.disp_valid !== 1'b0) begin bad++; $display("FAIL bp_xfer got out=%0d v=%b want 1 0", b.outstanding, b.disp_valid); end
        step();
    endtask

    task automatic test_concurrent_resp();
        set_req(3, 1'b1, 4'd9);
        push(3, 4'd9);
        smp();
        total++; if (b.port_read !== 4'b1000) begin bad++; $display("FAIL cr_grant got=%b want=1000", b.port_read); end
        step();
        set_req(3, 1'b0, 4'd0);
        b.resp_done = 1'b1;
        step();
        b.resp_done = 1'b0;
        smp();
        total++; if (b.outstanding !== 2'd1) begin bad++; $display("FAIL cr_both got=%0d want=1", b.outstanding); end
        b.resp_done = 1'b1;
        step();
        b.resp_done = 1'b0;
        smp();
        total++; if (b.outstanding !== 2'd0) begin bad++; $display("FAIL cr_dec got=%0d want=0", b.outstanding); end
        b.resp_done = 1'b1;
        step();
        b.resp_done = 1'b0;
        smp();
        total++; if (b.outstanding !== 2'd0) begin bad++; $display("FAIL cr_underflow got=%0d want=0", b.outstanding); end
        step();
    endtask

    task automatic test_arb_en_and_reset();
        b.arb_en = 1'b0;
        all_reqs(1);
        for (int j = 0; j < 3; j++) begin
            smp();
            total++; if (b.port_read !== 4'b0000 || b.arb_busy !== 1'b0) begin bad++; $display("FAIL en_off%0d got read=%b busy=%b want 0000 0", j, b.port_read, b.arb_busy); end
            step();
        end
        clear_reqs();
        set_req(1, 1'b1, 4'd6);
        b.arb_en = 1'b1;
        b.disp_ready = 1'b0;
        smp();
        total++; if (b.port_read !== 4'b0010) begin bad++; $display("FAIL en_on got=%b want=0010", b.port_read); end
        step();
        all_reqs(1);
        smp();
        total++; if (b.disp_valid !== 1'b1 || b.port_read !== 4'b0000) begin bad++; $display("FAIL mid_issue got v=%b read=%b want 1 0000", b.disp_valid, b.port_read); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        push(0, 4'd1);
        b.disp_ready = 1'b1;
        smp();
        total++; if (b.disp_valid !== 1'b0 || b.outstanding !== 2'd0 || b.arb_busy !== 1'b0) begin bad++; $display("FAIL mid_rst got v=%b out=%0d busy=%b want 0 0 0", b.disp_valid, b.outstanding, b.arb_busy); end
        total++; if (b.port_read !== 4'b0001) begin bad++; $display("FAIL mid_rst_grant got=%b want=0001", b.port_read); end
        step();
        clear_reqs();
        step();
        smp();
        total++; if (b.outstanding !== 2'd1) begin bad++; $display("FAIL mid_rst_out got=%0d want=1", b.outstanding); end
        step();
    endtask

    initial begin
        b.arb_en = 1'b0;
        b.disp_ready = 1'b0;
        b.resp_done = 1'b0;
        clear_reqs();
        test_reset();
        test_single_port();
        test_round_robin();
        test_max_outstanding();
        test_backpressure();
        test_concurrent_resp();
        test_arb_en_and_reset();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL sb_leftover got=%0d pending want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
